// File: rtl/mmio_bus_bridge_pkg.sv
// Shared types and default address map for the CPU-to-slave MMIO bridge.
// Also used by the SoC top so that the address map has a single source.
package mmio_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } bridge_state_t;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_GPIO = 2'd2
  } region_t;

  localparam logic [31:0] MMIO_RAM_BASE  = 32'h0000_0000;
  localparam logic [31:0] MMIO_RAM_TOP   = 32'h0000_07FF;
  localparam logic [31:0] MMIO_GPIO_BASE = 32'hFFFF_FFF0;
  localparam logic [31:0] MMIO_GPIO_TOP  = 32'hFFFF_FFF3;
  localparam logic [2:0]  MMIO_RAM_LAT   = 3'd1;
  localparam logic [2:0]  MMIO_GPIO_LAT  = 3'd1;

  // Offset form keeps the check valid (and free of constant compares) when base is 0.
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] base,
                                    input logic [31:0] top);
    return (addr - base) <= (top - base);
  endfunction

endpackage

// File: rtl/mmio_bus_bridge_addr_decode.sv
// Combinational byte-address to region decode; RAM takes priority on overlap.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = MMIO_RAM_BASE,
  parameter logic [31:0] RAM_TOP   = MMIO_RAM_TOP,
  parameter logic [31:0] GPIO_BASE = MMIO_GPIO_BASE,
  parameter logic [31:0] GPIO_TOP  = MMIO_GPIO_TOP
) (
  input  logic [31:0] addr,
  output region_t     region
);

  logic ram_hit_s;
  logic gpio_hit_s;

  assign ram_hit_s  = in_range(addr, RAM_BASE, RAM_TOP);
  assign gpio_hit_s = in_range(addr, GPIO_BASE, GPIO_TOP);

  // Priority select of the hit region.
  always_comb begin
    region = REG_NONE;
    if (ram_hit_s) begin
      region = REG_RAM;
    end else if (gpio_hit_s) begin
      region = REG_GPIO;
    end else begin
      region = REG_NONE;
    end
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Single-outstanding CPU load/store bridge onto the shared RAM/GPIO slave bus
// with per-region write strobes, fixed read latency and unmapped-access error.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = MMIO_RAM_BASE,
  parameter logic [31:0] RAM_TOP   = MMIO_RAM_TOP,
  parameter logic [31:0] GPIO_BASE = MMIO_GPIO_BASE,
  parameter logic [31:0] GPIO_TOP  = MMIO_GPIO_TOP,
  parameter logic [2:0]  RAM_LAT   = MMIO_RAM_LAT,
  parameter logic [2:0]  GPIO_LAT  = MMIO_GPIO_LAT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_be,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_err,
  output logic [31:0] memAddress,
  output logic [31:0] memWriteData,
  output logic [3:0]  byteMask,
  output logic        ram_we,
  output logic        gpio_we,
  input  logic [31:0] ram_rdata,
  input  logic [31:0] gpio_rdata
);

  bridge_state_t state_r;
  region_t       region_s;
  region_t       region_r;
  logic          we_r;
  logic [2:0]    cnt_r;
  logic [31:0]   sel_rdata_s;

  mmio_addr_decode #(
    .RAM_BASE  (RAM_BASE),
    .RAM_TOP   (RAM_TOP),
    .GPIO_BASE (GPIO_BASE),
    .GPIO_TOP  (GPIO_TOP)
  ) u_decode (
    .addr   (cpu_addr),
    .region (region_s)
  );

  // Read-data mux keyed on the latched region so an idle slave's Z never leaks through.
  always_comb begin
    sel_rdata_s = 32'd0;
    case (region_r)
      REG_RAM:  sel_rdata_s = ram_rdata;
      REG_GPIO: sel_rdata_s = gpio_rdata;
      default:  sel_rdata_s = 32'd0;
    endcase
  end

  // Bridge FSM with request latches, latency counter and registered CPU/slave outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      region_r     <= REG_NONE;
      we_r         <= 1'b0;
      cnt_r        <= 3'd0;
      cpu_rdata    <= 32'd0;
      cpu_ready    <= 1'b0;
      cpu_err      <= 1'b0;
      memAddress   <= 32'd0;
      memWriteData <= 32'd0;
      byteMask     <= 4'd0;
      ram_we       <= 1'b0;
      gpio_we      <= 1'b0;
    end else begin
      // Strobes and response fields are single-cycle pulses unless set below.
      ram_we    <= 1'b0;
      gpio_we   <= 1'b0;
      cpu_ready <= 1'b0;
      cpu_err   <= 1'b0;
      cpu_rdata <= 32'd0;
      case (state_r)
        IDLE: begin
          if (cpu_req) begin
            memAddress   <= cpu_addr;
            memWriteData <= cpu_wdata;
            byteMask     <= cpu_be;
            we_r         <= cpu_we;
            region_r     <= region_s;
            case (region_s)
              REG_RAM: begin
                state_r <= ACCESS;
                cnt_r   <= RAM_LAT;
                ram_we  <= cpu_we;
              end
              REG_GPIO: begin
                state_r <= ACCESS;
                cnt_r   <= GPIO_LAT;
                gpio_we <= cpu_we;
              end
              default: begin
                state_r   <= RESP;
                cnt_r     <= 3'd0;
                cpu_ready <= 1'b1;
                cpu_err   <= 1'b1;
              end
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt_r != 3'd0) begin
            cnt_r <= cnt_r - 3'd1;
          end else begin
            cpu_rdata <= we_r ? 32'd0 : sel_rdata_s;
            cpu_ready <= 1'b1;
            state_r   <= RESP;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_bus_bridge.sv
// Directed, table-driven bench for mmio_bus_bridge with behavioural RAM and GPIO slaves.
module tb_mmio_bus_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_be;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_err;
  logic [31:0] memAddress;
  logic [31:0] memWriteData;
  logic [3:0]  byteMask;
  logic        ram_we;
  logic        gpio_we;
  logic [31:0] ram_rdata;
  logic [31:0] gpio_rdata;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mmio_bus_bridge #(
    .RAM_LAT  (3'd3),
    .GPIO_LAT (3'd1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_be       (cpu_be),
    .cpu_rdata    (cpu_rdata),
    .cpu_ready    (cpu_ready),
    .cpu_err      (cpu_err),
    .memAddress   (memAddress),
    .memWriteData (memWriteData),
    .byteMask     (byteMask),
    .ram_we       (ram_we),
    .gpio_we      (gpio_we),
    .ram_rdata    (ram_rdata),
    .gpio_rdata   (gpio_rdata)
  );

  // Slave models: 16-word aliased RAM and one GPIO register, byte-masked writes.
  logic        mem_clr;
  logic [31:0] ram_mem [16];
  logic [31:0] gpio_reg;
  logic        gpio_sel;

  assign gpio_sel   = (memAddress >= 32'hFFFF_FFF0) && (memAddress <= 32'hFFFF_FFF3);
  assign ram_rdata  = ram_mem[memAddress[5:2]];
  assign gpio_rdata = gpio_sel ? gpio_reg : 32'hzzzz_zzzz;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 16; i++) ram_mem[i] <= 32'd0;
      gpio_reg <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (ram_we && byteMask[b]) ram_mem[memAddress[5:2]][8*b +: 8] <= memWriteData[8*b +: 8];
        if (gpio_we && gpio_sel && byteMask[b]) gpio_reg[8*b +: 8] <= memWriteData[8*b +: 8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        toggle;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          ram_strb;
    int          gpio_strb;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Issue one request, then watch a bounded window for ready, strobes and stray pulses.
  task automatic run_req(input vec_t v, input string tag);
    int k;
    int k_ready;
    int ram_n;
    int gpio_n;
    int ready_n;
    logic bad_idle;
    logic [31:0] rd;
    logic er;
    logic [31:0] ma;
    logic [31:0] md;
    logic [3:0]  mb;
    k_ready = 0; ram_n = 0; gpio_n = 0; ready_n = 0; bad_idle = 1'b0;
    rd = 32'd0; er = 1'b0; ma = 32'd0; md = 32'd0; mb = 4'd0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata; cpu_be = v.be;
    @(posedge clk);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      ram_n  += int'(ram_we);
      gpio_n += int'(gpio_we);
      if (cpu_ready) begin
        ready_n++;
        if (k_ready == 0) begin
          k_ready = k; rd = cpu_rdata; er = cpu_err; ma = memAddress; md = memWriteData; mb = byteMask;
        end
      end else if (cpu_err || (cpu_rdata != 32'd0)) begin
        bad_idle = 1'b1;
      end
      if (k_ready == 0 && v.toggle) cpu_req = ~cpu_req;
      else cpu_req = 1'b0;
      if (k_ready != 0 && k >= k_ready + 3) break;
    end
    cpu_req = 1'b0;
    chk({tag, " latency"},  32'(k_ready), 32'(v.lat));
    chk({tag, " rdata"},    rd, v.rdata);
    chk({tag, " err"},      32'(er), 32'(v.err));
    chk({tag, " ram_we_n"}, 32'(ram_n), 32'(v.ram_strb));
    chk({tag, " gpio_we_n"},32'(gpio_n), 32'(v.gpio_strb));
    chk({tag, " ready_n"},  32'(ready_n), 32'd1);
    chk({tag, " idle_outs"},32'(bad_idle), 32'd0);
    chk({tag, " mem_addr"}, ma, v.addr);
    chk({tag, " mem_wdata"},md, v.wdata);
    chk({tag, " byte_mask"},32'(mb), 32'(v.be));
  endtask

  initial begin
    int first_k;
    int second_k;
    int pulses;
    int gw_n;
    logic [31:0] second_rd;
    vec_t rv;

    vecs[0]  = '{1'b1, 32'hFFFF_FFF0, 32'h1F00_0000, 4'b1000, 1'b0, 3, 32'h0000_0000, 1'b0, 0, 1};
    vecs[1]  = '{1'b0, 32'hFFFF_FFF0, 32'h0000_0000, 4'b1111, 1'b0, 3, 32'h1F00_0000, 1'b0, 0, 0};
    vecs[2]  = '{1'b0, 32'h1000_0000, 32'h0000_0000, 4'b1111, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[3]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b1111, 1'b0, 5, 32'h0000_0000, 1'b0, 1, 0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b1, 5, 32'hDEAD_BEEF, 1'b0, 0, 0};
    vecs[5]  = '{1'b1, 32'h0000_07FC, 32'h1234_5678, 4'b0101, 1'b0, 5, 32'h0000_0000, 1'b0, 1, 0};
    vecs[6]  = '{1'b0, 32'h0000_07FC, 32'h0000_0000, 4'b1111, 1'b0, 5, 32'h0034_0078, 1'b0, 0, 0};
    vecs[7]  = '{1'b1, 32'h0000_0010, 32'h0000_0000, 4'b0000, 1'b0, 5, 32'h0000_0000, 1'b0, 1, 0};
    vecs[8]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'b1111, 1'b0, 5, 32'hDEAD_BEEF, 1'b0, 0, 0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'b1111, 1'b0, 5, 32'h0000_0000, 1'b0, 0, 0};
    vecs[10] = '{1'b0, 32'h0000_0800, 32'h0000_0000, 4'b1111, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[11] = '{1'b1, 32'hFFFF_FFF4, 32'hAAAA_5555, 4'b1111, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[12] = '{1'b0, 32'hFFFF_FFEF, 32'h0000_0000, 4'b1111, 1'b0, 1, 32'h0000_0000, 1'b1, 0, 0};
    vecs[13] = '{1'b1, 32'hFFFF_FFF3, 32'h0000_00AB, 4'b0001, 1'b0, 3, 32'h0000_0000, 1'b0, 0, 1};
    vecs[14] = '{1'b0, 32'hFFFF_FFF2, 32'h0000_0000, 4'b1111, 1'b0, 3, 32'h1F00_00AB, 1'b0, 0, 0};

    reset = 1'b1; mem_clr = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'd0; cpu_wdata = 32'd0; cpu_be = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst cpu_ready", 32'(cpu_ready), 32'd0);
    chk("rst cpu_err",   32'(cpu_err), 32'd0);
    chk("rst cpu_rdata", cpu_rdata, 32'd0);
    chk("rst memAddress", memAddress, 32'd0);
    chk("rst memWriteData", memWriteData, 32'd0);
    chk("rst byteMask",  32'(byteMask), 32'd0);
    chk("rst ram_we",    32'(ram_we), 32'd0);
    chk("rst gpio_we",   32'(gpio_we), 32'd0);
    reset = 1'b0; mem_clr = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 15; i++) run_req(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back GPIO write then read with cpu_req held high throughout.
    first_k = 0; second_k = 0; pulses = 0; gw_n = 0; second_rd = 32'd0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FFF0; cpu_wdata = 32'h0000_5500; cpu_be = 4'b0010;
    @(posedge clk);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      gw_n += int'(gpio_we);
      if (cpu_ready) begin
        pulses++;
        if (first_k == 0) begin
          first_k = k;
          cpu_we = 1'b0; cpu_wdata = 32'd0; cpu_be = 4'b1111;
        end else if (second_k == 0) begin
          second_k = k; second_rd = cpu_rdata; cpu_req = 1'b0;
        end
      end
    end
    cpu_req = 1'b0;
    chk("b2b first_ready", 32'(first_k), 32'd3);
    chk("b2b second_ready", 32'(second_k), 32'd7);
    chk("b2b pulses", 32'(pulses), 32'd2);
    chk("b2b gpio_we_n", 32'(gw_n), 32'd1);
    chk("b2b rdata", second_rd, 32'h1F00_55AB);

    // Reset asserted mid-ACCESS of a RAM write: strobe drops at once, no ready, write discarded.
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0020; cpu_wdata = 32'hCAFE_0000; cpu_be = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    cpu_req = 1'b0;
    chk("rstmid ram_we_before", 32'(ram_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstmid ram_we_after", 32'(ram_we), 32'd0);
    chk("rstmid memAddress", memAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pulses += int'(cpu_ready);
    end
    chk("rstmid no_ready", 32'(pulses), 32'd0);
    rv = '{1'b0, 32'h0000_0020, 32'h0000_0000, 4'b1111, 1'b0, 5, 32'h0000_0000, 1'b0, 0, 0};
    run_req(rv, "post_rst_read");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
